ddr2axis_rd: RTL
================

# ddr2axis_rd

AXI4-Full read master that fetches a fixed-size frame from DDR in INCR bursts and emits it as an AXI4-Stream with start-of-frame (TUSER) and end-of-frame (TLAST) marking. It is the read-back counterpart of `axis2ddr_top`: same base address, burst length and AXI data width. It down-converts each wide AXI read beat into narrow stream beats. It sits between the DDR slave (or the virtual AXI memory in simulation) and downstream stream consumers.

## Interface
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h10000000, byte address of frame start
- C_M_AXI_BURST_LEN, 16, beats per burst; one of 1, 2, 4, … 256
- C_M_AXI_ID_WIDTH, 1, ARID/RID width
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 128, AXI data width; integer multiple of C_M_AXIS_TDATA_WIDTH
- C_M_AXI_ARUSER_WIDTH / C_M_AXI_RUSER_WIDTH, 0 / 0, user widths; ARUSER driven 0
- C_M_AXIS_TDATA_WIDTH, 32, stream width
- C_FRAME_BURSTS, 4, bursts per frame (≥1)

Ports:
- M_AXI_ACLK, in, 1, single clock for all logic
- M_AXI_ARESETN, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse; begins a frame read when idle
- busy, out, 1, high from accepted start until done
- done, out, 1, one-cycle pulse after final stream handshake
- rd_err, out, 1, sticky: any RRESP≠0 seen; cleared by accepted start
- rlast_err, out, 1, sticky: RLAST position ≠ beat BURST_LEN-1; cleared by accepted start
- M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARUSER/ARVALID, out, AXI4 widths, read address channel
- M_AXI_ARREADY, in, 1
- M_AXI_RID/RDATA/RRESP/RLAST/RUSER/RVALID, in, AXI4 widths, read data channel
- M_AXI_RREADY, out, 1
- M_AXIS_TDATA, out, C_M_AXIS_TDATA_WIDTH, stream payload
- M_AXIS_TSTRB, out, C_M_AXIS_TDATA_WIDTH/8, constant all ones
- M_AXIS_TVALID / M_AXIS_TLAST / M_AXIS_TUSER, out, 1 each
- M_AXIS_TREADY, in, 1

## Operation
- Constants: BYTES = DATA_WIDTH/8, LANES = DATA_WIDTH/TDATA_WIDTH, BURST_BYTES = BURST_LEN·BYTES (256 at defaults).
- ARLEN = BURST_LEN-1; ARSIZE = clog2(BYTES); ARBURST = 2'b01; ARCACHE = 4'b0011; ARID, ARLOCK, ARPROT, ARQOS, ARUSER = 0.
- FSM:
  - IDLE -(start)-> AR.
  - AR: ARVALID=1, ARADDR = BASE + burst_idx·BURST_BYTES; -(ARREADY)-> RD.
  - RD: on the RVALID&&RREADY beat with beat_cnt = BURST_LEN-1, go to AR if burst_idx < C_FRAME_BURSTS-1, else DRAIN.
  - DRAIN -(last lane handshaken)-> IDLE, with done pulse.
- Exactly one burst outstanding. Bursts are counted by beat_cnt, not RLAST. RLAST is only checked, and a mismatch sets rlast_err.
- Down-converter:
  - One-beat holding register plus a lane index.
  - Lane 0 = RDATA[TDATA_WIDTH-1:0] is emitted first.
  - RREADY = (state==RD) && (!buf_valid || (lane==LANES-1 && TREADY)). This combinational TREADY→RREADY path is intentional and gives full throughput.
- TUSER=1 only on lane 0 of beat 0 of burst 0. TLAST=1 only on the last lane of the last beat of the last burst.
- start while busy is ignored. Every frame restarts at BASE.
- RID and RUSER are ignored. RRESP≠0 sets rd_err; the data is still forwarded and the frame completes.

## Timing
- Reset values: all outputs 0 except TSTRB (all ones) and ARLEN/ARSIZE/ARBURST/ARCACHE (constants). FSM=IDLE, buffer empty, counters 0.
- Reset mid-frame clears all state immediately (asynchronous); no partial-frame completion afterwards.
- ARVALID rises the cycle after start is accepted. AR→AR gap ≥1 cycle after the last R beat.
- Buffer loads on the RVALID&&RREADY edge, so TVALID rises one cycle after the first R handshake.
- AXIS: TDATA, TLAST and TUSER hold stable while TVALID && !TREADY. TVALID never drops without a handshake.
- With TREADY=1 and the slave streaming, the stream runs at 1 beat/cycle; RREADY duty is 1/LANES.
- done asserts the cycle after the TLAST handshake; busy falls in that same cycle.

## Structure
- Shared package `ddr2axis_pkg`: FSM state encoding (IDLE, AR, RD, DRAIN), AXI constant encodings (BURST_INCR, CACHE_BUFFERABLE_MODIFIABLE), clogb2 function.
- One sub-module, `axi_rd_downsizer`: holding register, lane index, RREADY generation, TUSER/TLAST tagging inputs. The top holds the FSM, address generation, counters and error flags.

## Test plan
- Defaults, TREADY=1, memory word n = n:
  - Four ARs at 0x10000000/100/200/300 with ARLEN=15, ARSIZE=4.
  - 256 stream beats with TDATA 0..255.
  - TUSER on beat 0 only, TLAST on beat 255 only; done one cycle later.
- RDATA 128'h00000003_00000002_00000001_00000000 → TDATA 0, 1, 2, 3 in order.
- TREADY random 50%: zero loss or duplication; outputs stable during stall; RREADY low while lanes are pending.
- RRESP=2'b10 on beat 5 of burst 1 → rd_err=1 sticky; still 256 beats and done. Next start clears rd_err.
- RLAST asserted on beat 14 → rlast_err=1; frame still ends after 16·4 beats.
- ARESETN low at stream beat 40 → all outputs at reset values that cycle. start after release → ARADDR=0x10000000. start while busy → no second AR.

Source files
------------

// File: rtl/ddr2axis_pkg.sv
// Shared types and AXI encodings for the DDR frame read-back master.
package ddr2axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AR    = 2'd1,
    ST_RD    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR                  = 2'b01;
  localparam logic [3:0] CACHE_BUFFERABLE_MODIFIABLE = 4'b0011;
  localparam logic [1:0] RESP_OKAY                   = 2'b00;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr2axis_if.sv
// AXI4 read channels plus the AXI4-Stream output of the frame reader.
// Every channel transfers on a clock edge where VALID && READY; once VALID is
// raised it, and its payload, stay unchanged until that transfer happens.
interface ddr2axis_if #(
  parameter int ID_W     = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 128,
  parameter int ARUSER_W = 0,
  parameter int RUSER_W  = 0,
  parameter int TDATA_W  = 32
);
  localparam int ARU_W = (ARUSER_W > 0) ? ARUSER_W : 1;
  localparam int RU_W  = (RUSER_W > 0) ? RUSER_W : 1;

  logic [ID_W-1:0]      ARID;
  logic [ADDR_W-1:0]    ARADDR;
  logic [7:0]           ARLEN;
  logic [2:0]           ARSIZE;
  logic [1:0]           ARBURST;
  logic                 ARLOCK;
  logic [3:0]           ARCACHE;
  logic [2:0]           ARPROT;
  logic [3:0]           ARQOS;
  logic [ARU_W-1:0]     ARUSER;
  logic                 ARVALID;
  logic                 ARREADY;

  logic [ID_W-1:0]      RID;
  logic [DATA_W-1:0]    RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic [RU_W-1:0]      RUSER;
  logic                 RVALID;
  logic                 RREADY;

  logic [TDATA_W-1:0]   TDATA;
  logic [TDATA_W/8-1:0] TSTRB;
  logic                 TVALID;
  logic                 TLAST;
  logic                 TUSER;
  logic                 TREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    output RREADY,
    output TDATA, TSTRB, TVALID, TLAST, TUSER,
    input  TREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    input  RREADY,
    input  TDATA, TSTRB, TVALID, TLAST, TUSER,
    output TREADY
  );

endinterface

// File: rtl/ddr2axis_rd_downsizer.sv
// Holds one wide AXI read beat and emits it lane by lane (lane 0 first) as
// narrow stream beats, tagging frame start/end from the beat's position.
module axi_rd_downsizer
  import ddr2axis_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int TDATA_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rd_en,
  input  logic               i_rvalid,
  input  logic [DATA_W-1:0]  i_rdata,
  input  logic               i_first,
  input  logic               i_last,
  input  logic               i_tready,
  output logic               o_rready,
  output logic               o_tvalid,
  output logic [TDATA_W-1:0] o_tdata,
  output logic               o_tuser,
  output logic               o_tlast,
  output logic               o_last_hs
);

  localparam int LANES  = DATA_W / TDATA_W;
  localparam int LANE_W = (LANES > 1) ? clogb2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [DATA_W-1:0]  r_buf;
  logic               r_buf_valid;
  logic [LANE_W-1:0]  r_lane;
  logic               r_first;
  logic               r_last;

  logic [TDATA_W-1:0] w_lanes [LANES];
  logic               w_on_last_lane;
  logic               w_t_hs;
  logic               w_load;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lanes[g] = r_buf[g*TDATA_W +: TDATA_W];
  end

  assign w_on_last_lane = (r_lane == LAST_LANE);
  assign w_t_hs         = r_buf_valid && i_tready;
  // A new beat may enter while the final lane is leaving, so the stream never
  // bubbles; this makes RREADY combinationally depend on TREADY.
  assign o_rready       = i_rd_en && (!r_buf_valid || (w_on_last_lane && i_tready));
  assign w_load         = o_rready && i_rvalid;

  assign o_tvalid  = r_buf_valid;
  assign o_tdata   = w_lanes[r_lane];
  assign o_tuser   = r_first && (r_lane == '0);
  assign o_tlast   = r_last && w_on_last_lane;
  assign o_last_hs = w_t_hs && o_tlast;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_lane      <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_load) begin
      r_buf       <= i_rdata;
      r_buf_valid <= 1'b1;
      r_lane      <= '0;
      r_first     <= i_first;
      r_last      <= i_last;
    end else if (w_t_hs) begin
      if (w_on_last_lane) begin
        r_buf_valid <= 1'b0;
        r_lane      <= '0;
      end else begin
        r_lane <= r_lane + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr2axis_rd.sv
// Frame reader: fetches C_FRAME_BURSTS INCR bursts from a fixed DDR base with
// one burst outstanding, and streams them out through the lane down-converter.
module ddr2axis_rd
  import ddr2axis_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h1000_0000,
  parameter int C_M_AXI_BURST_LEN    = 16,
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 128,
  parameter int C_M_AXI_ARUSER_WIDTH = 0,
  parameter int C_M_AXI_RUSER_WIDTH  = 0,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_FRAME_BURSTS       = 4
) (
  input  logic       M_AXI_ACLK,
  input  logic       M_AXI_ARESETN,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd_err,
  output logic       rlast_err,
  output state_t     dbg_state,
  ddr2axis_if.master m_axi
);

  localparam int BYTES       = C_M_AXI_DATA_WIDTH / 8;
  localparam int BURST_BYTES = C_M_AXI_BURST_LEN * BYTES;
  localparam int BEAT_W      = (C_M_AXI_BURST_LEN > 1) ? clogb2(C_M_AXI_BURST_LEN) : 1;
  localparam int BIDX_W      = (C_FRAME_BURSTS > 1) ? clogb2(C_FRAME_BURSTS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(C_M_AXI_BURST_LEN - 1);
  localparam logic [BIDX_W-1:0] LAST_BURST = BIDX_W'(C_FRAME_BURSTS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR =
    C_M_AXI_ADDR_WIDTH'(C_M_TARGET_SLAVE_BASE_ADDR);

  state_t                        r_state;
  logic [BIDX_W-1:0]             r_burst_idx;
  logic [BEAT_W-1:0]             r_beat_cnt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
  logic                          r_arvalid;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_rd_err;
  logic                          r_rlast_err;

  logic w_rready;
  logic w_r_hs;
  logic w_last_beat;
  logic w_last_burst;
  logic w_first_beat;
  logic w_last_hs;
  logic w_unused;

  assign w_r_hs       = w_rready && m_axi.RVALID;
  assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
  assign w_last_burst = (r_burst_idx == LAST_BURST);
  assign w_first_beat = (r_burst_idx == '0) && (r_beat_cnt == '0);
  // RID/RUSER carry nothing this reader needs.
  assign w_unused     = ^{m_axi.RID, m_axi.RUSER};

  assign m_axi.ARID    = '0;
  assign m_axi.ARADDR  = r_araddr;
  assign m_axi.ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi.ARSIZE  = 3'(clogb2(BYTES));
  assign m_axi.ARBURST = BURST_INCR;
  assign m_axi.ARLOCK  = 1'b0;
  assign m_axi.ARCACHE = CACHE_BUFFERABLE_MODIFIABLE;
  assign m_axi.ARPROT  = '0;
  assign m_axi.ARQOS   = '0;
  assign m_axi.ARUSER  = '0;
  assign m_axi.ARVALID = r_arvalid;
  assign m_axi.RREADY  = w_rready;
  assign m_axi.TSTRB   = '1;

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_err    = r_rd_err;
  assign rlast_err = r_rlast_err;
  assign dbg_state = r_state;

  axi_rd_downsizer #(
    .DATA_W  (C_M_AXI_DATA_WIDTH),
    .TDATA_W (C_M_AXIS_TDATA_WIDTH)
  ) u_downsizer (
    .i_clk     (M_AXI_ACLK),
    .i_rst_n   (M_AXI_ARESETN),
    .i_rd_en   (r_state == ST_RD),
    .i_rvalid  (m_axi.RVALID),
    .i_rdata   (m_axi.RDATA),
    .i_first   (w_first_beat),
    .i_last    (w_last_beat && w_last_burst),
    .i_tready  (m_axi.TREADY),
    .o_rready  (w_rready),
    .o_tvalid  (m_axi.TVALID),
    .o_tdata   (m_axi.TDATA),
    .o_tuser   (m_axi.TUSER),
    .o_tlast   (m_axi.TLAST),
    .o_last_hs (w_last_hs)
  );

  // Bursts end on our own beat count; RLAST is only cross-checked.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state     <= ST_IDLE;
      r_burst_idx <= '0;
      r_beat_cnt  <= '0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_err    <= 1'b0;
      r_rlast_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_rd_err    <= 1'b0;
            r_rlast_err <= 1'b0;
            r_burst_idx <= '0;
            r_beat_cnt  <= '0;
            r_araddr    <= BASE_ADDR;
            r_arvalid   <= 1'b1;
            r_state     <= ST_AR;
          end
        end
        ST_AR: begin
          if (m_axi.ARREADY) begin
            r_arvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= ST_RD;
          end
        end
        ST_RD: begin
          if (w_r_hs) begin
            if (m_axi.RRESP != RESP_OKAY) r_rd_err <= 1'b1;
            if (m_axi.RLAST != w_last_beat) r_rlast_err <= 1'b1;
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last_beat) begin
              if (w_last_burst) begin
                r_state <= ST_DRAIN;
              end else begin
                r_burst_idx <= r_burst_idx + 1'b1;
                r_araddr    <= r_araddr + C_M_AXI_ADDR_WIDTH'(BURST_BYTES);
                r_arvalid   <= 1'b1;
                r_state     <= ST_AR;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_last_hs) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
